// File: rtl/fpadd_sched.sv
// -----------------------------------------------------------------------------
// fpadd_sched
//   Round-robin scheduler that shares a single floating-point adder among NREQ
//   requesters. One operation is outstanding at a time:
//     IDLE  -> pick a requester (round robin from rr_ptr), latch its operands
//     ISSUE -> one-cycle add_start pulse to the adder
//     WAIT  -> wait for add_done (first cycle masked: done is stale there),
//              or give up after TIMEOUT cycles and return a quiet NaN + error
//     RESP  -> hold the tagged result on the valid/ready response port
//
// Ports
//   clk        in   1         clock, rising edge
//   reset      in   1         asynchronous, active-low reset
//   req_valid  in   NREQ      per-requester request valid
//   req_a      in   32*NREQ   operand A, requester i in bits [32i+31:32i]
//   req_b      in   32*NREQ   operand B, same packing as req_a
//   req_ready  out  NREQ      one-hot accept (combinational, IDLE only)
//   rsp_valid  out  1         response valid
//   rsp_ready  in   1         response accepted by the consumer
//   rsp_id     out  IDW       requester index of the response
//   rsp_sum    out  32        adder result (0x7FC00000 on timeout)
//   rsp_err    out  1         1 = adder timed out
//   busy       out  1         1 whenever the FSM is not in IDLE
//   add_start  out  1         adder start, one-cycle pulse
//   add_a      out  32        adder operand A, stable from ISSUE until IDLE
//   add_b      out  32        adder operand B, stable from ISSUE until IDLE
//   add_sum    in   32        adder result
//   add_done   in   1         adder done (level, stale until start is seen)
// -----------------------------------------------------------------------------
module fpadd_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 add_start,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_sum,
    input  logic                 add_done
);

    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]     QNAN   = 32'h7FC0_0000;
    localparam logic [IDW:0]    NREQ_W = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0]  ID_MAX = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_armed;
    logic [IDW-1:0]      r_rr_ptr;
    logic [IDW-1:0]      w_rr_nxt;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       w_timer_nxt;

    logic [31:0]         r_add_a;
    logic [31:0]         r_add_b;
    logic [31:0]         w_add_a_nxt;
    logic [31:0]         w_add_b_nxt;
    logic                r_add_start;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [IDW-1:0]      r_rsp_id;
    logic [IDW-1:0]      w_rsp_id_nxt;
    logic [31:0]         r_rsp_sum;
    logic [31:0]         w_rsp_sum_nxt;
    logic                r_rsp_err;
    logic                w_rsp_err_nxt;

    logic                w_any;
    logic [2*NREQ-1:0]   w_req2;
    logic [NREQ-1:0]     w_rot;
    logic [IDW-1:0]      w_k;
    logic [IDW:0]        w_sum_idx;
    logic [IDW-1:0]      w_gnt_idx;
    logic [NREQ-1:0]     w_gnt_oh;
    logic [31:0]         w_gnt_a;
    logic [31:0]         w_gnt_b;

    assign w_any  = |req_valid;
    // Doubling the valid vector turns "search upward from rr_ptr with wrap"
    // into a plain part-select followed by a lowest-bit priority search.
    assign w_req2 = {req_valid, req_valid};
    assign w_rot  = w_req2[r_rr_ptr +: NREQ];

    // Lowest set bit of the rotated request vector = offset from rr_ptr.
    always_comb begin
        w_k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_k = IDW'(i);
            end else begin
                w_k = w_k;
            end
        end
    end

    // Convert the offset back to an absolute requester index (mod NREQ).
    always_comb begin
        w_sum_idx = {1'b0, r_rr_ptr} + {1'b0, w_k};
        if (w_sum_idx >= NREQ_W) begin
            w_gnt_idx = IDW'(w_sum_idx - NREQ_W);
        end else begin
            w_gnt_idx = IDW'(w_sum_idx);
        end
    end

    assign w_gnt_oh = NREQ'(1'b1) << w_gnt_idx;
    assign w_gnt_a  = req_a[32*w_gnt_idx +: 32];
    assign w_gnt_b  = req_b[32*w_gnt_idx +: 32];

    // Combinational accept: only in IDLE, and never while reset is in effect
    // (r_armed is cleared by reset and set on the first clock afterwards).
    always_comb begin
        if ((r_state == S_IDLE) && r_armed && w_any) begin
            req_ready = w_gnt_oh;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and next-value logic for the scheduler FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_timer_nxt   = r_timer;
        w_add_a_nxt   = r_add_a;
        w_add_b_nxt   = r_add_b;
        w_rsp_id_nxt  = r_rsp_id;
        w_rsp_sum_nxt = r_rsp_sum;
        w_rsp_err_nxt = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (r_armed && w_any) begin
                    w_add_a_nxt  = w_gnt_a;
                    w_add_b_nxt  = w_gnt_b;
                    w_rsp_id_nxt = w_gnt_idx;
                    w_state_nxt  = S_ISSUE;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TW'(1);
                // timer==0 is the first WAIT cycle: add_done still reflects
                // the previous operation there, so it is ignored. Done is
                // tested before the timeout so it wins a same-cycle tie.
                if ((r_timer != '0) && add_done) begin
                    w_rsp_sum_nxt = add_sum;
                    w_rsp_err_nxt = 1'b0;
                    w_state_nxt   = S_RESP;
                end else if (r_timer == T_LAST) begin
                    w_rsp_sum_nxt = QNAN;
                    w_rsp_err_nxt = 1'b1;
                    w_state_nxt   = S_RESP;
                end else begin
                    w_state_nxt   = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (r_rsp_id == ID_MAX) begin
                        w_rr_nxt = '0;
                    end else begin
                        w_rr_nxt = r_rsp_id + IDW'(1);
                    end
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept enable: keeps req_ready low until the first clock after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Datapath and registered output flags, decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_add_a     <= 32'h0000_0000;
            r_add_b     <= 32'h0000_0000;
            r_rsp_id    <= '0;
            r_rsp_sum   <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_add_start <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rr_ptr    <= w_rr_nxt;
            r_timer     <= w_timer_nxt;
            r_add_a     <= w_add_a_nxt;
            r_add_b     <= w_add_b_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_sum   <= w_rsp_sum_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_add_start <= (w_state_nxt == S_ISSUE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RESP);
        end
    end

    assign add_start = r_add_start;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_fpadd_sched.sv
// -----------------------------------------------------------------------------
// tb_fpadd_sched
//   Directed, table-driven bench for fpadd_sched (NREQ=4, TIMEOUT=64).
//   A small adder stub answers add_start after a programmable latency with a
//   bench-chosen sum; its done output stays high until one cycle after the
//   next start, so the first WAIT cycle always sees a stale done.
// -----------------------------------------------------------------------------
module tb_fpadd_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_sum;
    logic               rsp_err;
    logic               busy;
    logic               add_start;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_sum;
    logic               add_done;

    int n_pass  = 0;
    int n_total = 0;

    fpadd_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_done  (add_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stub
    logic        stub_start_d;
    logic [7:0]  stub_cnt;
    logic        stub_done;
    logic [31:0] stub_q;
    logic [31:0] stub_sum;
    int          stub_lat;
    logic        stub_stuck;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_start_d <= 1'b0;
            stub_cnt     <= 8'd0;
            stub_done    <= 1'b0;
            stub_q       <= 32'h0;
        end else begin
            stub_start_d <= add_start;
            if (stub_start_d) begin
                stub_done <= 1'b0;
                stub_cnt  <= 8'(stub_lat);
            end else if (stub_cnt != 8'd0) begin
                stub_cnt <= stub_cnt - 8'd1;
                if (stub_cnt == 8'd1) begin
                    stub_done <= 1'b1;
                    stub_q    <= stub_sum;
                end
            end
        end
    end

    assign add_done = stub_done & ~stub_stuck;
    assign add_sum  = stub_q;

    typedef struct {
        logic [3:0]  valid;
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic [31:0] exp_sum;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present a request, wait for the accept and check the ISSUE cycle.
    // Returns at the negedge of the first WAIT cycle.
    task automatic start_op(input logic [3:0] valid, input logic [1:0] id,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] sum, input int lat);
        int n;
        @(negedge clk);
        stub_sum = sum;
        stub_lat = lat;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = (i == int'(id)) ? a : (32'hBAD0_0000 | 32'(i));
            req_b[i*32 +: 32] = (i == int'(id)) ? b : (32'hBEE0_0000 | 32'(i));
        end
        req_valid = valid;
        #1;
        n = 0;
        while (req_ready == 4'b0000 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_onehot", 32'(req_ready), 32'(4'b0001 << id));
        @(negedge clk);
        check("issue_start", 32'(add_start), 32'd1);
        check("issue_add_a", add_a, a);
        check("issue_add_b", add_b, b);
        check("issue_busy_noready", {27'd0, busy, req_ready}, {27'd0, 1'b1, 4'b0000});
        @(negedge clk);
        check("start_one_cycle", 32'(add_start), 32'd0);
    endtask

    task automatic wait_rsp(output int k);
        k = 1;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rsp_arrives", 32'(rsp_valid), 32'd1);
    endtask

    task automatic finish_op(input logic [1:0] id, input logic [31:0] exp_sum, input logic exp_err);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_sum", rsp_sum, exp_sum);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("back_idle", {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        rsp_ready = 1'b1;
        start_op(v.valid, v.id, v.a, v.b, v.sum, v.lat);
        wait_rsp(k);
        finish_op(v.id, v.exp_sum, v.exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {21'd0, busy, add_start, rsp_valid, rsp_err, req_ready, rsp_id}, 32'd0);
        check({tag, "_add_a"}, add_a, 32'd0);
        check({tag, "_add_b"}, add_b, 32'd0);
        check({tag, "_rsp_sum"}, rsp_sum, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [1:0]  h_id;
        logic [31:0] h_sum;

        // valid id  a  b  stub-sum  expected-sum  err  lat
        vecs[0]  = '{4'b0001, 2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1};
        vecs[1]  = '{4'b1111, 2'd1, 32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 32'h40E0_0000, 1'b0, 2};
        vecs[2]  = '{4'b1111, 2'd2, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3};
        vecs[3]  = '{4'b1111, 2'd3, 32'h4120_0000, 32'hC0A0_0000, 32'h40A0_0000, 32'h40A0_0000, 1'b0, 1};
        vecs[4]  = '{4'b1111, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 4};
        vecs[5]  = '{4'b0100, 2'd2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 1};
        vecs[6]  = '{4'b1001, 2'd3, 32'h42C8_0000, 32'h3F80_0000, 32'h42CA_0000, 32'h42CA_0000, 1'b0, 2};
        vecs[7]  = '{4'b1001, 2'd0, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[8]  = '{4'b0001, 2'd0, 32'h4049_0FDB, 32'h4049_0FDB, 32'h40C9_0FDB, 32'h40C9_0FDB, 1'b0, 5};
        vecs[9]  = '{4'b0110, 2'd1, 32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000, 32'h4120_0000, 1'b0, 62};
        vecs[10] = '{4'b0101, 2'd2, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 63};
        vecs[11] = '{4'b1110, 2'd3, 32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000, 32'h3F00_0000, 1'b0, 1};

        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        stub_sum   = 32'h0;
        stub_lat   = 1;
        stub_stuck = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {30'd0, busy, add_start}, 32'd0);

        // Single op, contention, fairness, wrap, done/timeout boundary, stale done
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: rsp_ready low for 5 response cycles, others keep asking
        rsp_ready = 1'b0;
        start_op(4'b1111, 2'd0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 2);
        wait_rsp(k);
        h_id  = 2'd0;
        h_sum = 32'h4080_0000;
        for (int c = 1; c <= 6; c++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'(h_id));
            check("bp_sum", rsp_sum, h_sum);
            check("bp_busy_noready", {27'd0, busy, req_ready}, {27'd0, 1'b1, 4'b0000});
            if (c == 6) begin
                rsp_ready = 1'b1;
                req_valid = 4'b0000;
            end
            @(negedge clk);
        end
        check("bp_handshake", {30'd0, rsp_valid, busy}, 32'd0);

        // Timeout: done never arrives
        stub_stuck = 1'b1;
        start_op(4'b0010, 2'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1);
        wait_rsp(k);
        check("timeout_wait_cycles", 32'(k), 32'(TIMEOUT + 1));
        finish_op(2'd1, 32'h7FC0_0000, 1'b1);
        stub_stuck = 1'b0;

        // Reset in the middle of WAIT aborts the op without a response
        rsp_ready = 1'b1;
        start_op(4'b0100, 2'd2, 32'h4040_0000, 32'h4040_0000, 32'h40C0_0000, 10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        @(negedge clk);
        check("reset_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("reset_no_rsp2", 32'(rsp_valid), 32'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        run_vec('{4'b1111, 2'd0, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 32'h4080_0000, 1'b0, 1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
